// File: rtl/stopwatch_display_scan.sv
// stopwatch_display_scan: snapshots hh/mm/ss/xx once per frame, converts to BCD, scans 8x 7-seg as hh.mm.ss.xx
// Optional leading-zero blanking of the hours tens digit with STOPWATCH_DISP_LZB_EN.
module stopwatch_display_scan #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int SCAN_HZ = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] hh,
    input  logic [7:0] mm,
    input  logic [7:0] ss,
    input  logic [7:0] xx,
    output logic [6:0] seg,
    output logic       dp,
    output logic [7:0] an,
    output logic       busy
);
    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int W = $clog2(DIV);

    typedef enum logic [1:0] {IDLE, LOAD, STEP, COMMIT} state_t;

    state_t     state;
    logic [W-1:0] cnt;
    logic [2:0] idx, nidx;
    logic       tick, blank;
    logic [31:0] snap, bcd, disp;
    logic [1:0] f;
    logic [6:0] rem, dec;
    logic [3:0] tens, digit;
    logic [7:0] v;

    assign tick  = cnt == W'(DIV - 1);
    assign nidx  = idx - 3'd1;
    assign digit = disp[4*nidx +: 4];
    assign v     = snap[8*(3-f) +: 8];

`ifdef STOPWATCH_DISP_LZB_EN
    assign blank = nidx == 3'd7 && disp[31:28] == 4'd0;
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        case (digit)
            4'd0: dec = 7'h3F;
            4'd1: dec = 7'h06;
            4'd2: dec = 7'h5B;
            4'd3: dec = 7'h4F;
            4'd4: dec = 7'h66;
            4'd5: dec = 7'h6D;
            4'd6: dec = 7'h7D;
            4'd7: dec = 7'h07;
            4'd8: dec = 7'h7F;
            4'd9: dec = 7'h6F;
            default: dec = 7'h00;
        endcase
    end

    // idx starts at 0, so the first tick wraps to 7 and counts as a frame start
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= 3'd0;
            an  <= 8'd0;
            seg <= 7'd0;
            dp  <= 1'b0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) begin
                idx <= nidx;
                an  <= 8'd1 << nidx;
                seg <= blank ? 7'd0 : dec;
                dp  <= nidx == 3'd6 || nidx == 3'd4 || nidx == 3'd2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            snap  <= '0;
            bcd   <= '0;
            disp  <= '0;
            f     <= 2'd0;
            rem   <= 7'd0;
            tens  <= 4'd0;
        end else begin
            case (state)
                IDLE: if (tick && idx == 3'd0) begin
                    snap  <= {hh, mm, ss, xx};
                    f     <= 2'd0;
                    busy  <= 1'b1;
                    state <= LOAD;
                end
                LOAD: begin
                    rem   <= v > 8'd99 ? 7'd99 : v[6:0];
                    tens  <= 4'd0;
                    state <= STEP;
                end
                STEP: if (rem >= 7'd10) begin
                    rem  <= rem - 7'd10;
                    tens <= tens + 4'd1;
                end else begin
                    bcd[8*(3-f) +: 8] <= {tens, rem[3:0]};
                    f     <= f + 2'd1;
                    state <= f == 2'd3 ? COMMIT : LOAD;
                end
                COMMIT: begin
                    disp  <= bcd;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stopwatch_display_scan.sv
// tb_stopwatch_display_scan: directed checks of scan order, BCD conversion, clamping, snapshot timing and reset.
module tb_stopwatch_display_scan;
    logic clk = 1'b0, rst = 1'b1;
    logic [7:0] hh = 8'd0, mm = 8'd0, ss = 8'd0, xx = 8'd0;
    logic [6:0] seg;
    logic dp, busy;
    logic [7:0] an;
    int errors = 0, checks = 0;

    logic [6:0] sc [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    logic [7:0] an_exp [8] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    logic dp_exp [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
`ifdef STOPWATCH_DISP_LZB_EN
    localparam logic [6:0] Z7 = 7'h00;
`else
    localparam logic [6:0] Z7 = 7'h3F;
`endif

    stopwatch_display_scan #(.CLK_HZ(64), .SCAN_HZ(1)) dut (
        .clk(clk), .rst(rst), .hh(hh), .mm(mm), .ss(ss), .xx(xx),
        .seg(seg), .dp(dp), .an(an), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        checks++;
        if (!$onehot0(an)) begin
            errors++;
            $display("FAIL onehot an=%h", an);
        end
    end

    task automatic do_reset(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s, input logic [7:0] x);
        hh = h; mm = m; ss = s; xx = x;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic next_digit(output int n);
        logic [7:0] o;
        o = an;
        n = 0;
        do begin
            @(posedge clk);
            #1 n++;
        end while (an === o && n < 200);
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL timeout waiting for scan tick an=%h", an);
        end
    endtask

    task automatic skip(input int k);
        int n;
        for (int i = 0; i < k; i++) next_digit(n);
    endtask

    task automatic check_digit(input string name, input logic [7:0] ea, input logic [6:0] es, input logic ed);
        int n;
        next_digit(n);
        checks += 3;
        if (an !== ea) begin errors++; $display("FAIL %s an=%h exp=%h", name, an, ea); end
        if (seg !== es) begin errors++; $display("FAIL %s seg=%h exp=%h", name, seg, es); end
        if (dp !== ed) begin errors++; $display("FAIL %s dp=%b exp=%b", name, dp, ed); end
    endtask

    task automatic test_reset;
        int n;
        hh = 8'd99; mm = 8'd99; ss = 8'd99; xx = 8'd99;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 checks += 4;
        if (seg !== 7'd0) begin errors++; $display("FAIL reset_seg seg=%h exp=0", seg); end
        if (an !== 8'd0) begin errors++; $display("FAIL reset_an an=%h exp=0", an); end
        if (dp !== 1'b0) begin errors++; $display("FAIL reset_dp dp=%b exp=0", dp); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy busy=%b exp=0", busy); end
        rst = 1'b0;
        next_digit(n);
        checks += 4;
        if (n != 64) begin errors++; $display("FAIL first_tick cycles=%0d exp=64", n); end
        if (an !== 8'h80) begin errors++; $display("FAIL first_an an=%h exp=80", an); end
        if (seg !== Z7) begin errors++; $display("FAIL first_seg seg=%h exp=%h", seg, Z7); end
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_rise busy=%b exp=1", busy); end
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        checks++;
        if (n != 45) begin errors++; $display("FAIL busy_len cycles=%0d exp=45", n); end
    endtask

    task automatic test_pattern;
        logic [6:0] e [8];
        e = '{sc[1], sc[2], sc[3], sc[4], sc[5], sc[6], sc[7], sc[8]};
        do_reset(8'd12, 8'd34, 8'd56, 8'd78);
        skip(8);
        for (int i = 0; i < 8; i++) check_digit("pattern", an_exp[i], e[i], dp_exp[i]);
    endtask

    task automatic test_lzb;
        do_reset(8'd0, 8'd34, 8'd56, 8'd78);
        skip(8);
        check_digit("lzb_d7", 8'h80, Z7, 1'b0);
        check_digit("lzb_d6", 8'h40, sc[0], 1'b1);
    endtask

    task automatic test_midframe;
        do_reset(8'd12, 8'd34, 8'd56, 8'd10);
        skip(13);
        xx = 8'd99;
        check_digit("mid_d2", 8'h04, sc[6], 1'b1);
        check_digit("mid_d1_old", 8'h02, sc[1], 1'b0);
        check_digit("mid_d0_old", 8'h01, sc[0], 1'b0);
        skip(6);
        check_digit("mid_d1_new", 8'h02, sc[9], 1'b0);
        check_digit("mid_d0_new", 8'h01, sc[9], 1'b0);
    endtask

    task automatic test_clamp;
        logic [6:0] e [8];
        e = '{sc[9], sc[9], sc[9], sc[9], sc[6], sc[0], sc[9], sc[9]};
        do_reset(8'd200, 8'd99, 8'd60, 8'd100);
        skip(8);
        for (int i = 0; i < 8; i++) check_digit("clamp", an_exp[i], e[i], dp_exp[i]);
    endtask

    task automatic test_rst_mid;
        int n;
        do_reset(8'd99, 8'd99, 8'd99, 8'd99);
        skip(8);
        check_digit("pre_rst_d7", 8'h80, sc[9], 1'b0);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 checks += 3;
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy busy=%b exp=0", busy); end
        if (an !== 8'd0) begin errors++; $display("FAIL rst_mid_an an=%h exp=0", an); end
        if (seg !== 7'd0) begin errors++; $display("FAIL rst_mid_seg seg=%h exp=0", seg); end
        rst = 1'b0;
        next_digit(n);
        checks += 3;
        if (n != 64) begin errors++; $display("FAIL rst_mid_tick cycles=%0d exp=64", n); end
        if (an !== 8'h80) begin errors++; $display("FAIL rst_mid_resume an=%h exp=80", an); end
        if (seg !== Z7) begin errors++; $display("FAIL rst_mid_cleared seg=%h exp=%h", seg, Z7); end
        check_digit("rst_mid_d6", 8'h40, sc[9], 1'b1);
    endtask

    initial begin
        test_reset;
        test_pattern;
        test_lzb;
        test_midframe;
        test_clamp;
        test_rst_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
